// File: rtl/button_reset_debouncer.sv
// Push-button front end: 2-FF synchronizer, debounce FSM, one-cycle press pulse
// and a fixed-width, re-triggerable reset request pulse.
module button_reset_debouncer #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int PULSE_CYCLES    = 4,
  parameter int CNT_W           = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_in,
  output logic btn_level,
  output logic press_pulse,
  output logic reset_req,
  output logic busy
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    CHK_PRESS = 2'd1,
    HELD      = 2'd2,
    CHK_REL   = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] DCNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] PCNT_LOAD = CNT_W'(PULSE_CYCLES);

  logic             sync_q1, sync_q2;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] dcnt_q, dcnt_d;
  logic [CNT_W-1:0] pcnt_q, pcnt_d;
  logic             level_q, level_d;
  logic             press_q, press_d;
  logic             req_q, req_d;
  logic             busy_q, busy_d;

  // Next-state logic for the debounce FSM and the reset-request stretcher.
  always_comb begin
    state_d = state_q;
    dcnt_d  = dcnt_q;
    level_d = level_q;
    press_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (sync_q2) begin
          state_d = CHK_PRESS;
          dcnt_d  = CNT_W'(1);
        end else begin
          dcnt_d  = '0;
        end
      end
      CHK_PRESS: begin
        if (!sync_q2) begin
          state_d = IDLE;
          dcnt_d  = '0;
        end else if (dcnt_q == DCNT_LAST) begin
          state_d = HELD;
          level_d = 1'b1;
          press_d = 1'b1;
          dcnt_d  = '0;
        end else begin
          dcnt_d  = dcnt_q + CNT_W'(1);
        end
      end
      HELD: begin
        if (!sync_q2) begin
          state_d = CHK_REL;
          dcnt_d  = CNT_W'(1);
        end else begin
          dcnt_d  = '0;
        end
      end
      CHK_REL: begin
        if (sync_q2) begin
          state_d = HELD;
          dcnt_d  = '0;
        end else if (dcnt_q == DCNT_LAST) begin
          state_d = IDLE;
          level_d = 1'b0;
          dcnt_d  = '0;
        end else begin
          dcnt_d  = dcnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        level_d = 1'b0;
        dcnt_d  = '0;
      end
    endcase

    // A new press reloads the stretcher, so overlapping presses merge into one pulse.
    if (press_d) begin
      pcnt_d = PCNT_LOAD;
      req_d  = 1'b1;
    end else if (pcnt_q != '0) begin
      pcnt_d = pcnt_q - CNT_W'(1);
      req_d  = (pcnt_q > CNT_W'(1));
    end else begin
      pcnt_d = '0;
      req_d  = 1'b0;
    end

    busy_d = (state_d == CHK_PRESS) || (state_d == CHK_REL);
  end

  // State registers; reset wins over every other event on the same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q1 <= 1'b0;
      sync_q2 <= 1'b0;
      state_q <= IDLE;
      dcnt_q  <= '0;
      pcnt_q  <= '0;
      level_q <= 1'b0;
      press_q <= 1'b0;
      req_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      sync_q1 <= btn_in;
      sync_q2 <= sync_q1;
      state_q <= state_d;
      dcnt_q  <= dcnt_d;
      pcnt_q  <= pcnt_d;
      level_q <= level_d;
      press_q <= press_d;
      req_q   <= req_d;
      busy_q  <= busy_d;
    end
  end

  assign btn_level   = level_q;
  assign press_pulse = press_q;
  assign reset_req   = req_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_button_reset_debouncer.sv
// Directed bench for button_reset_debouncer: two instances (D=4/P=3 and D=2/P=8);
// expected {btn_level, press_pulse, reset_req, busy} per edge go through a queue.
module tb_button_reset_debouncer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a = 1'b1, btn_a = 1'b0;
  logic lvl_a, pp_a, rr_a, busy_a;
  logic rst_b = 1'b1, btn_b = 1'b0;
  logic lvl_b, pp_b, rr_b, busy_b;

  button_reset_debouncer #(.DEBOUNCE_CYCLES(4), .PULSE_CYCLES(3), .CNT_W(8)) dut_a (
    .clk(clk), .reset(rst_a), .btn_in(btn_a),
    .btn_level(lvl_a), .press_pulse(pp_a), .reset_req(rr_a), .busy(busy_a)
  );

  button_reset_debouncer #(.DEBOUNCE_CYCLES(2), .PULSE_CYCLES(8), .CNT_W(8)) dut_b (
    .clk(clk), .reset(rst_b), .btn_in(btn_b),
    .btn_level(lvl_b), .press_pulse(pp_b), .reset_req(rr_b), .busy(busy_b)
  );

  int tests = 0;
  int fails = 0;
  logic [3:0] exp_q[$];

  // One clock on instance A: drive inputs, queue the expectation, compare after the edge.
  task automatic cyc_a(input logic btn, input logic rst, input logic [3:0] exp, input string tag);
    logic [3:0] e;
    logic [3:0] obs;
    btn_a = btn;
    rst_a = rst;
    exp_q.push_back(exp);
    @(posedge clk);
    #1;
    e   = exp_q.pop_front();
    obs = {lvl_a, pp_a, rr_a, busy_a};
    tests++;
    assert (obs === e) else begin
      fails++;
      $error("FAIL %s t=%0t lvl/pp/rr/busy observed=%b expected=%b", tag, $time, obs, e);
    end
  endtask

  task automatic cyc_b(input logic btn, input logic rst, input logic [3:0] exp, input string tag);
    logic [3:0] e;
    logic [3:0] obs;
    btn_b = btn;
    rst_b = rst;
    exp_q.push_back(exp);
    @(posedge clk);
    #1;
    e   = exp_q.pop_front();
    obs = {lvl_b, pp_b, rr_b, busy_b};
    tests++;
    assert (obs === e) else begin
      fails++;
      $error("FAIL %s t=%0t lvl/pp/rr/busy observed=%b expected=%b", tag, $time, obs, e);
    end
  endtask

  initial begin
    // 1. reset, then clean press: level on edge 6, pulse 1 cycle, reset_req 3 cycles
    cyc_a(1'b0, 1'b1, 4'b0000, "t1_reset0");
    cyc_a(1'b0, 1'b1, 4'b0000, "t1_reset1");
    cyc_a(1'b1, 1'b0, 4'b0000, "t1_e1");
    cyc_a(1'b1, 1'b0, 4'b0000, "t1_e2");
    cyc_a(1'b1, 1'b0, 4'b0001, "t1_e3");
    cyc_a(1'b1, 1'b0, 4'b0001, "t1_e4");
    cyc_a(1'b1, 1'b0, 4'b0001, "t1_e5");
    cyc_a(1'b1, 1'b0, 4'b1110, "t1_e6_press");
    cyc_a(1'b1, 1'b0, 4'b1010, "t1_e7");
    cyc_a(1'b1, 1'b0, 4'b1010, "t1_e8");
    cyc_a(1'b1, 1'b0, 4'b1000, "t1_e9_req_end");
    cyc_a(1'b1, 1'b0, 4'b1000, "t1_e10");

    // 3. release from HELD: level falls 6 edges later, no pulse, no reset_req
    cyc_a(1'b0, 1'b0, 4'b1000, "t3_e1");
    cyc_a(1'b0, 1'b0, 4'b1000, "t3_e2");
    cyc_a(1'b0, 1'b0, 4'b1001, "t3_e3");
    cyc_a(1'b0, 1'b0, 4'b1001, "t3_e4");
    cyc_a(1'b0, 1'b0, 4'b1001, "t3_e5");
    cyc_a(1'b0, 1'b0, 4'b0000, "t3_e6_release");
    cyc_a(1'b0, 1'b0, 4'b0000, "t3_e7");

    // 2. bounce 1,1,0,1,1,0: busy pulses, nothing accepted
    cyc_a(1'b1, 1'b0, 4'b0000, "t2_e1");
    cyc_a(1'b1, 1'b0, 4'b0000, "t2_e2");
    cyc_a(1'b0, 1'b0, 4'b0001, "t2_e3");
    cyc_a(1'b1, 1'b0, 4'b0001, "t2_e4");
    cyc_a(1'b1, 1'b0, 4'b0000, "t2_e5");
    cyc_a(1'b0, 1'b0, 4'b0001, "t2_e6");
    cyc_a(1'b0, 1'b0, 4'b0001, "t2_e7");
    cyc_a(1'b0, 1'b0, 4'b0000, "t2_e8");
    cyc_a(1'b0, 1'b0, 4'b0000, "t2_e9");
    cyc_a(1'b0, 1'b0, 4'b0000, "t2_e10");

    // 5. reset in CHK_PRESS (dcnt=2) with button held, then a fresh press
    cyc_a(1'b1, 1'b0, 4'b0000, "t5_e1");
    cyc_a(1'b1, 1'b0, 4'b0000, "t5_e2");
    cyc_a(1'b1, 1'b0, 4'b0001, "t5_e3");
    cyc_a(1'b1, 1'b0, 4'b0001, "t5_e4");
    cyc_a(1'b1, 1'b1, 4'b0000, "t5_reset_edge");
    cyc_a(1'b1, 1'b0, 4'b0000, "t5_r1");
    cyc_a(1'b1, 1'b0, 4'b0000, "t5_r2");
    cyc_a(1'b1, 1'b0, 4'b0001, "t5_r3");
    cyc_a(1'b1, 1'b0, 4'b0001, "t5_r4");
    cyc_a(1'b1, 1'b0, 4'b0001, "t5_r5");
    cyc_a(1'b1, 1'b0, 4'b1110, "t5_r6_press");
    cyc_a(1'b1, 1'b0, 4'b1010, "t5_r7");
    cyc_a(1'b1, 1'b0, 4'b1010, "t5_r8");
    cyc_a(1'b1, 1'b0, 4'b1000, "t5_r9");

    // 6. reset on the very edge a press would be accepted
    cyc_a(1'b0, 1'b1, 4'b0000, "t6_clear");
    cyc_a(1'b1, 1'b0, 4'b0000, "t6_e1");
    cyc_a(1'b1, 1'b0, 4'b0000, "t6_e2");
    cyc_a(1'b1, 1'b0, 4'b0001, "t6_e3");
    cyc_a(1'b1, 1'b0, 4'b0001, "t6_e4");
    cyc_a(1'b1, 1'b0, 4'b0001, "t6_e5");
    cyc_a(1'b1, 1'b1, 4'b0000, "t6_e6_reset");
    cyc_a(1'b0, 1'b0, 4'b0000, "t6_after1");
    cyc_a(1'b0, 1'b0, 4'b0000, "t6_after2");
    cyc_a(1'b0, 1'b0, 4'b0000, "t6_after3");

    // 4. D=2/P=8: second press 6 cycles after the first keeps reset_req continuous
    cyc_b(1'b0, 1'b1, 4'b0000, "t4_reset");
    cyc_b(1'b1, 1'b0, 4'b0000, "t4_e1");
    cyc_b(1'b1, 1'b0, 4'b0000, "t4_e2");
    cyc_b(1'b1, 1'b0, 4'b0001, "t4_e3");
    cyc_b(1'b1, 1'b0, 4'b1110, "t4_e4_press1");
    cyc_b(1'b0, 1'b0, 4'b1010, "t4_e5");
    cyc_b(1'b0, 1'b0, 4'b1010, "t4_e6");
    cyc_b(1'b1, 1'b0, 4'b1011, "t4_e7");
    cyc_b(1'b1, 1'b0, 4'b0010, "t4_e8");
    cyc_b(1'b1, 1'b0, 4'b0011, "t4_e9");
    cyc_b(1'b1, 1'b0, 4'b1110, "t4_e10_press2");
    for (int i = 11; i <= 17; i++) begin
      cyc_b(1'b1, 1'b0, 4'b1010, $sformatf("t4_e%0d", i));
    end
    cyc_b(1'b1, 1'b0, 4'b1000, "t4_e18_req_end");
    cyc_b(1'b1, 1'b0, 4'b1000, "t4_e19");

    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain left=%0d required=0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
